req_encoder: RTL and testbench

- Sequential priority encoder, the counterpart of the one-hot decoder.
- Collects multi-hot request lines into a pending register and emits one binary index per valid/ready handshake.
- Used to encode pending events (exceptions, IRQ lines, unit requests) into an index for the rv32i control path.
- Each served line is cleared from pending; requests that arrive again while pending coalesce into one.

---
 rtl/req_encoder.sv | 139 +++++++++++++
 tb/tb_req_encoder.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/req_encoder.sv
// -----------------------------------------------------------------------------
// req_encoder
//
// Sequential priority encoder. Multi-hot request events are collected into a
// pending register and served one binary index at a time through a
// valid/ready output stage. A served line is cleared from pending; repeated
// events on a line that is already pending coalesce into a single entry.
//
// Configuration macro:
//   REQ_ENCODER_RR_EN  defined   -> round-robin selection. The search starts
//                                   one above the last served index and wraps.
//                      undefined -> fixed priority, lowest index wins. No
//                                   pointer register exists in this build.
//
// Parameters:
//   IN_WIDTH   number of request lines (>= 2, power of 2)
//   OUT_WIDTH  width of the encoded index, $clog2(IN_WIDTH)
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   en         request capture enable (0 masks req_in; pending still drains)
//   clr        synchronous clear of pending, output stage and pointer
//   req_in     request events, one event per line per cycle the bit is high
//   out_valid  out_idx holds a served request
//   out_ready  consumer accepts out_idx
//   out_idx    binary index of the served line
//   pend       registered pending vector, not yet selected
//   busy       out_valid | (|pend)
// -----------------------------------------------------------------------------
module req_encoder #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = $clog2(IN_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 clr,
  input  logic [IN_WIDTH-1:0]  req_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_idx,
  output logic [IN_WIDTH-1:0]  pend,
  output logic                 busy
);

  logic [IN_WIDTH-1:0]  cand;      // pending plus this cycle's accepted events
  logic                 load;      // output stage is empty or being emptied
  logic [OUT_WIDTH-1:0] sel_idx;   // winner of the selection over cand
  logic [IN_WIDTH-1:0]  sel_mask;  // one-hot of sel_idx
  logic                 cand_any;

  assign cand     = pend | (en ? req_in : '0);
  assign cand_any = |cand;
  assign load     = !out_valid || out_ready;
  assign sel_mask = IN_WIDTH'(1) << sel_idx;

`ifdef REQ_ENCODER_RR_EN
  // Index of the most recently loaded line. Resets to the top line so the
  // first search starts at index 0.
  logic [OUT_WIDTH-1:0] ptr;
  logic [OUT_WIDTH-1:0] probe;
  logic                 found;

  // Walk upward from ptr+1. IN_WIDTH is a power of 2, so truncating the sum
  // to OUT_WIDTH bits gives the modulo wrap for free.
  always_comb begin
    // NOTE: every variable assigned in a combinational block gets a default
    // first; otherwise a path that skips the assignment infers a latch.
    sel_idx = '0;
    found   = 1'b0;
    probe   = '0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      probe = ptr + OUT_WIDTH'(i + 1);
      if (!found && cand[probe]) begin
        found   = 1'b1;
        sel_idx = probe;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= OUT_WIDTH'(IN_WIDTH - 1);
    end else if (clr) begin
      ptr <= OUT_WIDTH'(IN_WIDTH - 1);
    end else if (load && cand_any) begin
      ptr <= sel_idx;
    end
  end
`else
  logic found;

  // Fixed priority: the first set bit scanning upward from 0 wins.
  always_comb begin
    // NOTE: every variable assigned in a combinational block gets a default
    // first; otherwise a path that skips the assignment infers a latch.
    sel_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      if (!found && cand[i]) begin
        found   = 1'b1;
        sel_idx = OUT_WIDTH'(i);
      end
    end
  end
`endif

  // Pending register and output stage. A line loaded this cycle is masked out
  // of the new pending value, so an event arriving on it in the same cycle is
  // consumed by the load. While stalled, everything in cand stays pending,
  // including a line that currently sits in the output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (!rst_n) begin
      pend      <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
    end else if (clr) begin
      pend      <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      if (cand_any) begin
        out_valid <= 1'b1;
        out_idx   <= sel_idx;
        pend      <= cand & ~sel_mask;
      end else begin
        out_valid <= 1'b0;
        pend      <= '0;
      end
    end else begin
      pend <= cand;
    end
  end

  assign busy = out_valid | (|pend);

endmodule

// File: tb/tb_req_encoder.sv
// -----------------------------------------------------------------------------
// tb_req_encoder
//
// Self-checking bench for req_encoder (IN_WIDTH = 16). Each scenario pushes
// the indices it expects onto a scoreboard queue; cycle() pops and compares
// one entry on every valid/ready transfer it observes at a clock edge.
// Scenarios also check pend/out_valid/out_idx/busy directly at key points.
// -----------------------------------------------------------------------------
module tb_req_encoder;

  localparam int W  = 16;
  localparam int OW = 4;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic          clr;
  logic [W-1:0]  req_in;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_idx;
  logic [W-1:0]  pend;
  logic          busy;

  int n_checks;
  int n_fail;
  int exp_q[$];

  req_encoder #(.IN_WIDTH(W), .OUT_WIDTH(OW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .clr       (clr),
    .req_in    (req_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .pend      (pend),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock. A transfer is decided by the values present just
  // before the edge; the transferred index is popped and compared after it.
  // Returns 1 ns after the edge, where inputs are driven and outputs sampled.
  task automatic cycle();
    logic          xfer;
    logic [OW-1:0] idx;
    int            e;
    xfer = out_valid && out_ready;
    idx  = out_idx;
    @(posedge clk);
    #1;
    if (xfer) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: transfer of idx %0d, none expected", idx);
      end else begin
        e = exp_q.pop_front();
        if (idx !== OW'(e)) begin
          n_fail++;
          $display("FAIL sb_idx: got idx %0d, expected %0d", idx, e);
        end
      end
    end
  endtask

  // Run until the scoreboard is empty or the budget expires.
  task automatic drain(input string name, input int budget);
    int left;
    left = budget;
    while (exp_q.size() > 0 && left > 0) begin
      cycle();
      left--;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d entries left after %0d cycles, expected 0",
               name, exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  // One clear cycle with the consumer idle, so it never overlaps a transfer.
  task automatic do_clr();
    out_ready = 1'b0;
    req_in    = '0;
    clr       = 1'b1;
    cycle();
    clr       = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; clr = 1'b0; req_in = '0; out_ready = 1'b0;
    #3;
    n_checks++;
    if (out_valid !== 1'b0 || pend !== '0 || busy !== 1'b0 || out_idx !== '0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b pend=%h busy=%b idx=%0d, expected 0/0000/0/0",
               out_valid, pend, busy, out_idx);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Build pend=00F0 behind a stalled idx 0, then reset asynchronously.
    req_in = 16'h0001;
    cycle();
    req_in = 16'h00F0;
    cycle();
    req_in = '0;
    n_checks++;
    if (out_valid !== 1'b1 || pend !== 16'h00F0) begin
      n_fail++;
      $display("FAIL reset_pre: valid=%b pend=%h, expected 1/00f0", out_valid, pend);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || pend !== '0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: valid=%b pend=%h busy=%b, expected 0/0000/0",
               out_valid, pend, busy);
    end
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    n_checks++;
    if (out_valid !== 1'b0 || pend !== '0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: valid=%b pend=%h busy=%b, expected 0/0000/0",
               out_valid, pend, busy);
    end
  endtask

  task automatic test_single();
    do_clr();
    out_ready = 1'b1;
    req_in = 16'h0020;
    exp_q.push_back(5);
    cycle();
    req_in = '0;
    n_checks++;
    if (out_valid !== 1'b1 || out_idx !== 4'd5 || pend !== '0) begin
      n_fail++;
      $display("FAIL single_latency: valid=%b idx=%0d pend=%h, expected 1/5/0000",
               out_valid, out_idx, pend);
    end
    cycle();
    n_checks++;
    if (out_valid !== 1'b0 || pend !== '0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL single_after: valid=%b pend=%h left=%0d, expected 0/0000/0",
               out_valid, pend, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_multi();
    do_clr();
    out_ready = 1'b1;
    req_in = 16'h8421;
    exp_q.push_back(0); exp_q.push_back(5); exp_q.push_back(10); exp_q.push_back(15);
    cycle();
    req_in = '0;
    for (int i = 0; i < 4; i++) cycle();
    n_checks++;
    if (exp_q.size() != 0 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL multi_throughput: left=%0d valid=%b busy=%b, expected 0/0/0",
               exp_q.size(), out_valid, busy);
    end
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    do_clr();
    req_in = 16'h0006;
    cycle();
    req_in = 16'h0004;  // repeat of a pending line coalesces
    cycle();
    req_in = '0;
    cycle();
    n_checks++;
    if (out_valid !== 1'b1 || out_idx !== 4'd1 || pend !== 16'h0004) begin
      n_fail++;
      $display("FAIL bp_hold: valid=%b idx=%0d pend=%h, expected 1/1/0004",
               out_valid, out_idx, pend);
    end
    exp_q.push_back(1); exp_q.push_back(2);
    out_ready = 1'b1;
    drain("bp", 10);
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_after: valid=%b busy=%b, expected 0/0", out_valid, busy);
    end
  endtask

  task automatic test_back_to_back();
    // Line 3 sits in the output stage; a new event on it must re-pend.
    do_clr();
    req_in = 16'h0008;
    cycle();
    cycle();
    req_in = '0;
    n_checks++;
    if (out_idx !== 4'd3 || pend !== 16'h0008) begin
      n_fail++;
      $display("FAIL b2b_repend: idx=%0d pend=%h, expected 3/0008", out_idx, pend);
    end
    exp_q.push_back(3); exp_q.push_back(3);
    out_ready = 1'b1;
    drain("b2b", 10);
    n_checks++;
    if (out_valid !== 1'b0 || pend !== '0) begin
      n_fail++;
      $display("FAIL b2b_after: valid=%b pend=%h, expected 0/0000", out_valid, pend);
    end
  endtask

  task automatic test_clr_en();
    do_clr();
    en = 1'b0; req_in = 16'hFFFF; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    n_checks++;
    if (out_valid !== 1'b0 || pend !== '0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL en_mask: valid=%b pend=%h busy=%b, expected 0/0000/0",
               out_valid, pend, busy);
    end

    en = 1'b1; out_ready = 1'b0;
    req_in = 16'h0001;
    cycle();
    req_in = 16'h0300;
    cycle();
    n_checks++;
    if (pend !== 16'h0300 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_pre: pend=%h valid=%b, expected 0300/1", pend, out_valid);
    end
    clr = 1'b1; req_in = 16'hFFFF;
    cycle();
    clr = 1'b0; req_in = '0;
    n_checks++;
    if (pend !== '0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_effect: pend=%h valid=%b, expected 0000/0", pend, out_valid);
    end
    out_ready = 1'b1;
    cycle(); cycle();
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_discard: valid=%b busy=%b, expected 0/0", out_valid, busy);
    end

    // With en low, existing pending entries still drain.
    out_ready = 1'b0;
    req_in = 16'h0011;
    cycle();
    en = 1'b0; req_in = 16'hFFFF; out_ready = 1'b1;
    exp_q.push_back(0); exp_q.push_back(4);
    drain("en_drain", 10);
    n_checks++;
    if (out_valid !== 1'b0 || pend !== '0) begin
      n_fail++;
      $display("FAIL en_drain_after: valid=%b pend=%h, expected 0/0000", out_valid, pend);
    end
    en = 1'b1; req_in = '0;
  endtask

  task automatic test_all_high();
    do_clr();
    out_ready = 1'b1;
    req_in = 16'hFFFF;
    for (int i = 0; i < W; i++) exp_q.push_back(i);
    cycle();
    req_in = '0;
    n_checks++;
    if (out_idx !== 4'd0 || pend !== 16'hFFFE) begin
      n_fail++;
      $display("FAIL all_first: idx=%0d pend=%h, expected 0/fffe", out_idx, pend);
    end
    drain("all", 40);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL all_after: busy=%b, expected 0", busy);
    end
  endtask

  task automatic test_select_mode();
    do_clr();
    out_ready = 1'b1;
    req_in = 16'h0009;
`ifdef REQ_ENCODER_RR_EN
    exp_q.push_back(0); exp_q.push_back(3); exp_q.push_back(0); exp_q.push_back(3);
    exp_q.push_back(0);
`else
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
    exp_q.push_back(3);
`endif
    for (int i = 0; i < 4; i++) cycle();
    req_in = '0;
    drain("mode", 10);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mode_after: busy=%b, expected 0", busy);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single();
    test_multi();
    test_backpressure();
    test_back_to_back();
    test_clr_en();
    test_all_high();
    test_select_mode();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
